// File: rtl/bus_uart_tx_if.sv
// 6502-style register bus between a state-machine master and bus_uart_tx.
// Signals: A (reg select), Din/Dout (data), CS/CS_n (selects), R_W_n, IRQ_n.
interface bus_uart_tx_if;
    logic [1:0] A;
    logic [7:0] Din;
    logic [7:0] Dout;
    logic       CS;
    logic       CS_n;
    logic       R_W_n;
    logic       IRQ_n;

    modport master (
        output A, Din, CS, CS_n, R_W_n,
        input  Dout, IRQ_n
    );

    modport slave (
        input  A, Din, CS, CS_n, R_W_n,
        output Dout, IRQ_n
    );
endinterface

// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter: FIFO-fed 8N1 (8E1 with UART_TX_PARITY_EN).
// Ports: clk, reset (sync, active-high), bus (slave modport), uartTx (idle high).
module bus_uart_tx #(
    parameter logic [15:0] DIV_RESET = 16'd234,
    parameter int          FIFO_AW   = 2
) (
    input  logic           clk,
    input  logic           reset,
    bus_uart_tx_if.slave   bus,
    output logic           uartTx
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic               sel, wr, rd;
    logic               push_req, push, pop;
    logic               full, empty, busy;
    logic               irq_en, irq_pend, irq_n_q, ovf;
    logic [15:0]        div;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    state_t             state, state_d;
    logic [15:0]        cnt, cnt_d;
    logic [7:0]         shift, shift_d;
    logic [2:0]         idx, idx_d;
`ifdef UART_TX_PARITY_EN
    logic               par, par_d;
`endif

    assign sel      = bus.CS & ~bus.CS_n;
    assign wr       = sel & ~bus.R_W_n;
    assign rd       = sel & bus.R_W_n;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign irq_pend = irq_en & empty & ~busy;
    assign bus.IRQ_n = irq_n_q;

    assign push_req = wr & (bus.A == 2'd0);
    assign pop      = (state == IDLE) & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.Din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req & full & ~pop) begin
                ovf <= 1'b1;
            end else if (rd & (bus.A == 2'd1)) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= DIV_RESET;
            irq_en  <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= ~irq_pend;
            if (wr) begin
                unique case (bus.A)
                    2'd1:    irq_en    <= bus.Din[0];
                    2'd2:    div[7:0]  <= bus.Din;
                    2'd3:    div[15:8] <= bus.Din;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            idx   <= '0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            shift <= shift_d;
            idx   <= idx_d;
`ifdef UART_TX_PARITY_EN
            par   <= par_d;
`endif
        end
    end

    // Divisor is only sampled on reload, so DIV writes apply from the next bit.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shift_d = shift;
        idx_d   = idx;
`ifdef UART_TX_PARITY_EN
        par_d   = par;
`endif
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    cnt_d   = div;
                    shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^mem[rd_ptr];
`endif
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_d = DATA;
                    cnt_d   = div;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_d = div;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx + 3'd1;
                        shift_d = shift >> 1;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt == 16'd0) begin
                    state_d = STOP;
                    cnt_d   = div;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uartTx = 1'b1;
        unique case (state)
            START:   uartTx = 1'b0;
            DATA:    uartTx = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  uartTx = par;
`endif
            default: uartTx = 1'b1;
        endcase
    end

    always_comb begin
        bus.Dout = 8'h00;
        if (rd) begin
            unique case (bus.A)
                2'd1:    bus.Dout = {irq_pend, 3'b000, ovf, empty, full, busy};
                2'd2:    bus.Dout = div[7:0];
                2'd3:    bus.Dout = div[15:8];
                default: bus.Dout = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Randomised bench for bus_uart_tx against a frame-level reference model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_bus_uart_tx;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    logic uartTx;

    bus_uart_tx_if bus ();

    bus_uart_tx #(
        .DIV_RESET (16'd234),
        .FIFO_AW   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .uartTx (uartTx)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending bytes plus the frame in flight,
    // described as a bit array where every bit lasts DIV+1 clocks, with
    // DIV taken at the moment that bit begins.
    logic [7:0]  q[$];
    logic        m_act;
    logic        m_bits [0:10];
    int          m_bidx, m_rem;
    logic        m_ovf, m_irq_en, m_irqn, m_valid = 1'b0;
    logic [15:0] m_div;

    always @(posedge clk) begin : model
        logic       sel, wr, rd, pop, full_pre, pend;
        logic [7:0] f;
        if (reset) begin
            q.delete();
            m_act    = 1'b0;
            m_bidx   = 0;
            m_rem    = 0;
            m_ovf    = 1'b0;
            m_irq_en = 1'b0;
            m_div    = 16'd234;
            m_irqn   = 1'b1;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            sel      = bus.CS & !bus.CS_n;
            wr       = sel & !bus.R_W_n;
            rd       = sel & bus.R_W_n;
            full_pre = (q.size() == DEPTH);
            pend     = m_irq_en && (q.size() == 0) && !m_act;
            m_irqn   = !pend;
            pop      = !m_act && (q.size() != 0);
            if (m_act) begin
                if (m_rem == 1) begin
                    if (m_bidx == FL - 1) begin
                        m_act = 1'b0;
                    end else begin
                        m_bidx++;
                        m_rem = int'(m_div) + 1;
                    end
                end else begin
                    m_rem--;
                end
            end
            if (pop) begin
                f = q.pop_front();
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[i+1] = f[i];
`ifdef UART_TX_PARITY_EN
                m_bits[9]  = ^f;
                m_bits[10] = 1'b1;
`else
                m_bits[9]  = 1'b1;
`endif
                m_act  = 1'b1;
                m_bidx = 0;
                m_rem  = int'(m_div) + 1;
            end
            if (wr) begin
                case (bus.A)
                    2'd0: begin
                        if (!full_pre || pop) q.push_back(bus.Din);
                        else m_ovf = 1'b1;
                    end
                    2'd1: m_irq_en = bus.Din[0];
                    2'd2: m_div[7:0] = bus.Din;
                    default: m_div[15:8] = bus.Din;
                endcase
            end
            if (rd && bus.A == 2'd1) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        return m_act ? m_bits[m_bidx] : 1'b1;
    endfunction

    function automatic logic [7:0] exp_dout();
        logic emp;
        emp = (q.size() == 0);
        if (!(bus.CS && !bus.CS_n && bus.R_W_n)) return 8'h00;
        case (bus.A)
            2'd0: return 8'h00;
            2'd1: return {m_irq_en && emp && !m_act, 3'b000, m_ovf, emp,
                          q.size() == DEPTH, m_act};
            2'd2: return m_div[7:0];
            default: return m_div[15:8];
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("uartTx", uartTx, exp_tx());
            check("IRQ_n", bus.IRQ_n, m_irqn);
            check("Dout", bus.Dout, exp_dout());
        end
    end

    logic       s_tx, s_irq;
    logic [7:0] s_d;

    task automatic drive(input logic r, input logic cs, input logic csn,
                         input logic rw, input logic [1:0] a,
                         input logic [7:0] d);
        reset     = r;
        bus.CS    = cs;
        bus.CS_n  = csn;
        bus.R_W_n = rw;
        bus.A     = a;
        bus.Din   = d;
        @(negedge clk);
        s_tx  = uartTx;
        s_d   = bus.Dout;
        s_irq = bus.IRQ_n;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        drive(1'b0, 1'b1, 1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        drive(1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h00);
    endtask

    task automatic drain(input string name);
        int t;
        for (t = 0; t < 3000; t++) begin
            rd(2'd1);
            if (s_d[2] && !s_d[0]) break;
        end
        check(name, {63'b0, t < 3000}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [10:0] fr;
    logic [63:0] got_v, exp_v;
    logic        cap [0:99];
    logic        saw_low;
    int          nb, p, r0, r1, r2;
    logic [1:0]  ra;
    logic [7:0]  rdat;
    logic        rcs, rcsn, rrw;
    int          rsel;

    initial begin
        reset = 1'b1;
        bus.CS = 1'b0; bus.CS_n = 1'b1; bus.R_W_n = 1'b1;
        bus.A = 2'd0; bus.Din = 8'h00;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 8'h00);

        rd(2'd1);
        check("rst_status", s_d, 8'h04);
        check("rst_tx", s_tx, 1'b1);
        check("rst_irqn", s_irq, 1'b1);
        rd(2'd2);
        check("rst_div_lo", s_d, 8'hEA);
        rd(2'd3);
        check("rst_div_hi", s_d, 8'h00);

        // Single frame 0xA5 at DIV=3, STATUS polled throughout.
        wr(2'd2, 8'd3);
        wr(2'd3, 8'd0);
        wr(2'd0, 8'hA5);
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        fr = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        got_v = '0; exp_v = '0; nb = 0;
        for (int k = 0; k < FL * 4 + 3; k++) begin
            rd(2'd1);
            got_v[k] = s_tx;
            nb += int'(s_d[0]);
            exp_v[k] = (k >= 1 && k <= FL * 4) ? fr[(k-1)/4] : 1'b1;
        end
        check("a5_frame", got_v, exp_v);
        check("a5_busy_cycles", nb, FL * 4);

        // Overflow: six back-to-back pushes, one pop in between.
        for (int i = 1; i <= 6; i++) wr(2'd0, 8'(i));
        rd(2'd1);
        check("ovf_status", s_d, 8'h0B);
        rd(2'd1);
        check("ovf_cleared", s_d, 8'h03);
        drain("ovf_drain");
        rd(2'd1);
        check("idle_status", s_d, 8'h04);

        // IRQ enable and its suppression while a frame is pending.
        wr(2'd1, 8'h01);
        idle();
        check("irq_lag", s_irq, 1'b1);
        idle();
        check("irq_on", s_irq, 1'b0);
        wr(2'd0, 8'h3C);
        idle();
        check("irq_still_low", s_irq, 1'b0);
        idle();
        check("irq_busy_high", s_irq, 1'b1);
        drain("irq_drain");
        idle();
        idle();
        check("irq_back_low", s_irq, 1'b0);
        wr(2'd1, 8'h00);

        // Reset in the middle of data bit 3 with a byte still queued.
        wr(2'd0, 8'h00);
        wr(2'd0, 8'h55);
        for (int i = 0; i < 16; i++) idle();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 8'h00);
        check("pre_reset_tx", s_tx, 1'b0);
        idle();
        check("post_reset_tx", s_tx, 1'b1);
        rd(2'd1);
        check("post_reset_status", s_d, 8'h04);
        saw_low = 1'b0;
        for (int i = 0; i < 80; i++) begin
            idle();
            if (!s_tx) saw_low = 1'b1;
        end
        check("no_frame_after_reset", saw_low, 1'b0);

        // DIV 3 -> 7 during START.
        wr(2'd2, 8'd3);
        wr(2'd0, 8'h01);
        idle();
        wr(2'd2, 8'd7);
        cap[0] = s_tx;
        for (int i = 1; i < 80; i++) begin
            idle();
            cap[i] = s_tx;
        end
        p = 0; r0 = 0; r1 = 0; r2 = 0;
        while (p < 80 && cap[p] == 1'b0) begin r0++; p++; end
        while (p < 80 && cap[p] == 1'b1) begin r1++; p++; end
        while (p < 80 && cap[p] == 1'b0) begin r2++; p++; end
        check("div_chg_start_len", r0, 4);
        check("div_chg_bit0_len", r1, 8);
        check("div_chg_bits1_7_len", r2, 56);
        drain("div_chg_drain");

        // DIV=0: one clock per bit.
        wr(2'd2, 8'd0);
        wr(2'd0, 8'h5A);
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, 1'b0, 8'h5A, 1'b0};
`else
        fr = {1'b0, 1'b1, 8'h5A, 1'b0};
`endif
        got_v = '0; exp_v = '0;
        for (int k = 0; k < FL + 2; k++) begin
            idle();
            got_v[k] = s_tx;
            exp_v[k] = (k >= 1 && k <= FL) ? fr[k-1] : 1'b1;
        end
        check("div0_frame", got_v, exp_v);

        // Random bus traffic with small divisors.
        for (int n = 0; n < 1500; n++) begin
            rsel = $urandom_range(0, 15);
            rcs  = (rsel != 0);
            rcsn = (rsel == 1);
            rrw  = 1'($urandom_range(0, 1));
            ra   = 2'($urandom_range(0, 3));
            if (!rrw && $urandom_range(0, 1) == 1) ra = 2'd0;
            rdat = 8'($urandom);
            if (ra == 2'd2) rdat = 8'($urandom_range(0, 2));
            if (ra == 2'd3) rdat = 8'h00;
            drive(1'b0, rcs, rcsn, rrw, ra, rdat);
        end
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
